cw305_trigger_seq: RTL and testbench

Parametrised run/trigger sequencer between the register block's start pulse and the crypto core on the CW305 target, in the crypto clock domain. Replaces fixed glue (trigger = core busy, header trigger tied high) with batched back-to-back encryptions, several independently programmable trigger channels (delay/width), a busy-based fallback mode and a watchdog timeout. Its outputs drive `tio_trigger` and the 40-pin header trigger in the top level.

---
 rtl/cw305_trig_pkg.sv | 20 ++
 rtl/cw305_trig_chan.sv | 50 +++++
 rtl/cw305_trigger_seq.sv | 145 ++++++++++++++
 tb/tb_cw305_trigger_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cw305_trig_pkg.sv
// Shared types and defaults for the CW305 run/trigger sequencer.
// Channel fields are packed LSB-first into flat vectors; field_lsb locates them.
package cw305_trig_pkg;

    localparam int DEF_NUM_TRIG      = 2;
    localparam int DEF_CNT_WIDTH     = 16;
    localparam int DEF_BATCH_WIDTH   = 8;
    localparam int DEF_TIMEOUT_WIDTH = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_t;

    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/cw305_trig_chan.sv
// One trigger channel: a delay/width window on the in-run cycle counter,
// or a busy-follower when width is zero. Output is registered.
module cw305_trig_chan
    import cw305_trig_pkg::*;
#(
    parameter int pCNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                  crypto_clk,
    input  logic                  resetn,
    input  logic [pCNT_WIDTH-1:0] t_i,
    input  logic                  in_run_i,
    input  logic                  core_busy_i,
    input  logic [pCNT_WIDTH-1:0] delay_i,
    input  logic [pCNT_WIDTH-1:0] width_i,
    output logic                  trig_o
);

    logic [pCNT_WIDTH:0] end_sum;
    logic                after_delay;
    logic                in_window;
    logic                trig_next;
    logic                trig_reg;

    // One extra bit keeps delay+width from wrapping back into range.
    assign end_sum     = {1'b0, delay_i} + {1'b0, width_i};
    assign after_delay = (t_i >= delay_i);
    assign in_window   = after_delay && ({1'b0, t_i} < end_sum);

    always_comb begin
        trig_next = 1'b0;
        if (in_run_i) begin
            if (width_i == '0) begin
                trig_next = after_delay && core_busy_i;
            end else begin
                trig_next = in_window;
            end
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (!resetn) begin
            trig_reg <= 1'b0;
        end else begin
            trig_reg <= trig_next;
        end
    end

    assign trig_o = trig_reg;

endmodule

// File: rtl/cw305_trigger_seq.sv
// Batched encryption sequencer for the CW305 target: issues core load pulses,
// runs programmable trigger channels and aborts stuck encryptions via a watchdog.
module cw305_trigger_seq
    import cw305_trig_pkg::*;
#(
    parameter int pNUM_TRIG      = DEF_NUM_TRIG,
    parameter int pCNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int pBATCH_WIDTH   = DEF_BATCH_WIDTH,
    parameter int pTIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
    input  logic                            crypto_clk,
    input  logic                            resetn,
    input  logic                            start_i,
    input  logic [pBATCH_WIDTH-1:0]         batch_i,
    input  logic [pNUM_TRIG*pCNT_WIDTH-1:0] trig_delay_i,
    input  logic [pNUM_TRIG*pCNT_WIDTH-1:0] trig_width_i,
    input  logic [pTIMEOUT_WIDTH-1:0]       timeout_i,
    input  logic                            core_busy_i,
    output logic                            core_load_o,
    output logic [pNUM_TRIG-1:0]            trig_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            timeout_o,
    output logic [pBATCH_WIDTH-1:0]         run_cnt_o
);

    localparam int CMP_W = (pCNT_WIDTH > pTIMEOUT_WIDTH) ? pCNT_WIDTH : pTIMEOUT_WIDTH;

    seq_state_t                      state_reg, state_next;
    logic [pCNT_WIDTH-1:0]           t_reg, t_next;
    logic [pBATCH_WIDTH-1:0]         run_cnt_reg, run_cnt_next, run_cnt_inc;
    logic [pBATCH_WIDTH-1:0]         batch_sh_reg;
    logic [pNUM_TRIG*pCNT_WIDTH-1:0] delay_sh_reg, width_sh_reg;
    logic [pTIMEOUT_WIDTH-1:0]       timeout_sh_reg, timeout_m1;
    logic                            done_reg, done_next;
    logic                            timeout_reg, timeout_next;
    logic                            load_reg, busy_reg;
    logic                            accept, complete, wd_hit, in_run_next;

    assign run_cnt_inc = run_cnt_reg + 1'b1;
    assign timeout_m1  = timeout_sh_reg - 1'b1;
    assign complete    = (state_reg == ST_RUN) && (t_reg != '0) && !core_busy_i;
    assign wd_hit      = (state_reg == ST_RUN) && (timeout_sh_reg != '0) && core_busy_i &&
                         (CMP_W'(t_reg) == CMP_W'(timeout_m1));
    assign in_run_next = (state_next == ST_RUN);

    always_comb begin
        state_next   = state_reg;
        t_next       = t_reg;
        run_cnt_next = run_cnt_reg;
        done_next    = done_reg;
        timeout_next = timeout_reg;
        accept       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    accept       = 1'b1;
                    run_cnt_next = '0;
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    state_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                t_next     = '0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (t_reg != '1) begin
                    t_next = t_reg + 1'b1;
                end
                // Completion wins over a watchdog hit on the same cycle.
                if (complete) begin
                    run_cnt_next = run_cnt_inc;
                    if (run_cnt_inc == batch_sh_reg) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end else if (wd_hit) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge crypto_clk) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            t_reg          <= '0;
            run_cnt_reg    <= '0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            load_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            batch_sh_reg   <= '0;
            delay_sh_reg   <= '0;
            width_sh_reg   <= '0;
            timeout_sh_reg <= '0;
        end else begin
            state_reg   <= state_next;
            t_reg       <= t_next;
            run_cnt_reg <= run_cnt_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            load_reg    <= (state_next == ST_LOAD);
            busy_reg    <= (state_next != ST_IDLE);
            if (accept) begin
                batch_sh_reg   <= (batch_i == '0) ? pBATCH_WIDTH'(1) : batch_i;
                delay_sh_reg   <= trig_delay_i;
                width_sh_reg   <= trig_width_i;
                timeout_sh_reg <= timeout_i;
            end
        end
    end

    // Channels see next-cycle t so their registered outputs line up with t.
    genvar gi;
    generate
        for (gi = 0; gi < pNUM_TRIG; gi++) begin : g_chan
            cw305_trig_chan #(
                .pCNT_WIDTH (pCNT_WIDTH)
            ) u_chan (
                .crypto_clk  (crypto_clk),
                .resetn      (resetn),
                .t_i         (t_next),
                .in_run_i    (in_run_next),
                .core_busy_i (core_busy_i),
                .delay_i     (delay_sh_reg[field_lsb(gi, pCNT_WIDTH) +: pCNT_WIDTH]),
                .width_i     (width_sh_reg[field_lsb(gi, pCNT_WIDTH) +: pCNT_WIDTH]),
                .trig_o      (trig_o[gi])
            );
        end
    endgenerate

    assign core_load_o = load_reg;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign timeout_o   = timeout_reg;
    assign run_cnt_o   = run_cnt_reg;

endmodule

// File: tb/tb_cw305_trigger_seq.sv
// Scoreboard bench for cw305_trigger_seq: directed sequences push expected
// per-sequence summaries; a monitor accumulates DUT behaviour and compares at sequence end.
module tb_cw305_trigger_seq;

    localparam int NT = 2;
    localparam int CW = 16;
    localparam int BW = 8;
    localparam int TW = 20;

    logic            crypto_clk = 1'b0;
    logic            resetn     = 1'b0;
    logic            start_i    = 1'b0;
    logic [BW-1:0]   batch_i    = '0;
    logic [NT*CW-1:0] trig_delay_i = '0;
    logic [NT*CW-1:0] trig_width_i = '0;
    logic [TW-1:0]   timeout_i  = '0;
    logic            core_busy_i;
    logic            core_load_o;
    logic [NT-1:0]   trig_o;
    logic            busy_o;
    logic            done_o;
    logic            timeout_o;
    logic [BW-1:0]   run_cnt_o;

    cw305_trigger_seq #(
        .pNUM_TRIG      (NT),
        .pCNT_WIDTH     (CW),
        .pBATCH_WIDTH   (BW),
        .pTIMEOUT_WIDTH (TW)
    ) dut (
        .crypto_clk   (crypto_clk),
        .resetn       (resetn),
        .start_i      (start_i),
        .batch_i      (batch_i),
        .trig_delay_i (trig_delay_i),
        .trig_width_i (trig_width_i),
        .timeout_i    (timeout_i),
        .core_busy_i  (core_busy_i),
        .core_load_o  (core_load_o),
        .trig_o       (trig_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .run_cnt_o    (run_cnt_o)
    );

    always #5 crypto_clk = ~crypto_clk;

    // Crypto core model: busy for busy_len cycles after a load, or stuck high.
    int busy_len   = 0;
    bit core_stuck = 1'b0;
    int core_cnt;
    always_ff @(posedge crypto_clk) begin
        if (!resetn) begin
            core_cnt <= 0;
        end else if (core_load_o) begin
            core_cnt <= busy_len;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
    end
    assign core_busy_i = core_stuck || (core_cnt != 0);

    typedef struct {
        bit done;
        bit tmo;
        int cnt;
        int loads;
        int cyc;
        int hi0;
        int f0;
        int hi1;
        int f1;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int stray = 0;
    int txn   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, compares when busy_o drops.
    initial begin
        bit   busy_prev = 1'b0;
        bit   busy_now;
        int   loads_m = 0, cyc_m = 0, seq_m = 0, t_m = 0;
        int   hi_m[NT];
        int   first_m[NT];
        exp_t e;
        for (int k = 0; k < NT; k++) begin
            hi_m[k]    = 0;
            first_m[k] = -1;
        end
        forever begin
            @(negedge crypto_clk);
            busy_now = (busy_o === 1'b1);
            if (busy_now && !busy_prev) begin
                loads_m = 0;
                cyc_m   = 0;
                seq_m   = 0;
                for (int k = 0; k < NT; k++) begin
                    hi_m[k]    = 0;
                    first_m[k] = -1;
                end
            end
            if (busy_now) begin
                cyc_m++;
                if (core_load_o === 1'b1) begin
                    if (int'(run_cnt_o) != loads_m) seq_m++;
                    loads_m++;
                    t_m = -1;
                end else begin
                    t_m++;
                end
                for (int k = 0; k < NT; k++) begin
                    if (trig_o[k] === 1'b1) begin
                        if (core_load_o === 1'b1) begin
                            stray++;
                        end else begin
                            hi_m[k]++;
                            if (first_m[k] < 0) first_m[k] = t_m;
                        end
                    end
                end
            end else if (busy_o === 1'b0) begin
                if (trig_o !== '0 || core_load_o !== 1'b0) stray++;
            end
            if (!busy_now && busy_prev) begin
                txn++;
                if (sb.size() == 0) begin
                    check($sformatf("t%0d_sb_underflow", txn), 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("txn %0d: done=%0b tmo=%0b cnt=%0d loads=%0d cyc=%0d hi0=%0d f0=%0d hi1=%0d f1=%0d",
                             txn, done_o, timeout_o, run_cnt_o, loads_m, cyc_m,
                             hi_m[0], first_m[0], hi_m[1], first_m[1]);
                    check($sformatf("t%0d_done", txn),     int'(done_o),    int'(e.done));
                    check($sformatf("t%0d_timeout", txn),  int'(timeout_o), int'(e.tmo));
                    check($sformatf("t%0d_run_cnt", txn),  int'(run_cnt_o), e.cnt);
                    check($sformatf("t%0d_loads", txn),    loads_m,         e.loads);
                    check($sformatf("t%0d_busy_cyc", txn), cyc_m,           e.cyc);
                    check($sformatf("t%0d_hi0", txn),      hi_m[0],         e.hi0);
                    check($sformatf("t%0d_first0", txn),   first_m[0],      e.f0);
                    check($sformatf("t%0d_hi1", txn),      hi_m[1],         e.hi1);
                    check($sformatf("t%0d_first1", txn),   first_m[1],      e.f1);
                    check($sformatf("t%0d_cnt_seq", txn),  seq_m,           0);
                    check($sformatf("t%0d_stray", txn),    stray,           0);
                    check($sformatf("t%0d_end_trig", txn), int'(trig_o),    0);
                    check($sformatf("t%0d_end_load", txn), int'(core_load_o), 0);
                end
            end
            busy_prev = busy_now;
        end
    end

    task automatic run_txn(input int batch, input int d0, input int w0, input int d1, input int w1,
                           input int tmo, input int blen, input bit stuck, input int poke,
                           input bit rst_mid, input bit e_done, input bit e_tmo, input int e_cnt,
                           input int e_loads, input int e_cyc, input int e_hi0, input int e_f0,
                           input int e_hi1, input int e_f1);
        exp_t e;
        int   n;
        e.done = e_done; e.tmo = e_tmo; e.cnt = e_cnt; e.loads = e_loads; e.cyc = e_cyc;
        e.hi0 = e_hi0; e.f0 = e_f0; e.hi1 = e_hi1; e.f1 = e_f1;
        sb.push_back(e);
        batch_i      = BW'(batch);
        trig_delay_i = {CW'(d1), CW'(d0)};
        trig_width_i = {CW'(w1), CW'(w0)};
        timeout_i    = TW'(tmo);
        busy_len     = blen;
        core_stuck   = stuck;
        @(negedge crypto_clk);
        start_i = 1'b1;
        @(negedge crypto_clk);
        start_i = 1'b0;
        if (poke > 0) begin
            repeat (poke) @(negedge crypto_clk);
            start_i      = 1'b1;
            batch_i      = BW'(5);
            trig_delay_i = '0;
            @(negedge crypto_clk);
            start_i = 1'b0;
        end
        if (rst_mid) begin
            n = 0;
            while (run_cnt_o !== BW'(1) && n < 200) begin
                @(negedge crypto_clk);
                n++;
            end
            if (n >= 200) check("run_cnt_wait_expired", 1, 0);
            repeat (3) @(negedge crypto_clk);
            resetn = 1'b0;
            @(negedge crypto_clk);
            resetn = 1'b1;
        end
        n = 0;
        while (busy_o !== 1'b0 && n < 3000) begin
            @(negedge crypto_clk);
            n++;
        end
        if (n >= 3000) check("busy_wait_expired", 1, 0);
        core_stuck = 1'b0;
        repeat (4) @(negedge crypto_clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge crypto_clk);
        check("rst_busy",    int'(busy_o),      0);
        check("rst_load",    int'(core_load_o), 0);
        check("rst_trig",    int'(trig_o),      0);
        check("rst_done",    int'(done_o),      0);
        check("rst_timeout", int'(timeout_o),   0);
        check("rst_run_cnt", int'(run_cnt_o),   0);
        resetn = 1'b1;
        repeat (2) @(negedge crypto_clk);

        //      batch d0      w0      d1      w1      tmo blen stk poke rst  done tmo cnt lds cyc hi0 f0 hi1 f1
        run_txn(1,    0,      0,      0,      1,      0,  10,  0,  0,   0,   1,   0,  1,  1,  12, 10, 1, 1,  0);
        run_txn(1,    0,      0,      3,      2,      0,  20,  0,  0,   0,   1,   0,  1,  1,  22, 20, 1, 2,  3);
        run_txn(4,    0,      0,      3,      2,      0,  5,   0,  0,   0,   1,   0,  4,  4,  28, 20, 1, 8,  3);
        run_txn(1,    2,      3,      5,      0,      8,  0,   1,  0,   0,   0,   1,  0,  1,  9,  3,  2, 3,  5);
        run_txn(1,    0,      0,      0,      1,      8,  4,   0,  0,   0,   1,   0,  1,  1,  6,  4,  1, 1,  0);
        run_txn(1,    'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 0,  98,  0,  10,  0,   1,   0,  1,  1,  100, 0, -1, 0, -1);
        run_txn(3,    0,      0,      3,      2,      0,  10,  0,  0,   1,   0,   0,  0,  2,  16, 12, 1, 2,  3);
        run_txn(0,    0,      0,      3,      2,      0,  3,   0,  0,   0,   1,   0,  1,  1,  5,  3,  1, 1,  3);

        repeat (4) @(negedge crypto_clk);
        check("sb_left", sb.size(), 0);
        check("txn_seen", txn, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
